// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: issues credited reads, absorbs RD_LATENCY
// and presents words as a valid/ready stream. Optional flush: FIFO_RD_STREAM_FLUSH_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
    input  logic                           empty,
    input  logic [DATA_WIDTH-1:0]          rdata,
    output logic                           r_en,
    output logic                           m_valid,
    output logic [DATA_WIDTH-1:0]          m_data,
    input  logic                           m_ready,
`ifdef FIFO_RD_STREAM_FLUSH_EN
    input  logic                           flush,
`endif
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = OCC_W + 2;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;
    logic [CNT_W-1:0]      inflight;
    logic                  pop, arrive, do_wr, flush_now;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Stream handshake: a word transfers on every rclk edge where m_valid & m_ready;
    // m_valid only drops after such a transfer and m_data holds while stalled.
    assign m_valid   = (occ_q != '0);
    assign m_data    = buf_q[rd_ptr_q];
    assign occupancy = occ_q;

    always_comb begin
        flush_now = 1'b0;
`ifdef FIFO_RD_STREAM_FLUSH_EN
        flush_now = flush;
`endif
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(infl_q[i]);
        end
        pop    = m_valid & m_ready & ~flush_now;
        arrive = infl_q[RD_LATENCY-1];
        // Credit counts buffered plus in-flight words; a same-cycle pop frees a slot.
        r_en   = rrst_n & ~empty & ~flush_now &
                 ((CNT_W'(occ_q) + inflight - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));
        infl_d[0] = r_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            infl_d[i] = infl_q[i-1];
        end
        do_wr    = arrive & ((occ_q != OCC_W'(BUF_DEPTH)) | pop);
        wr_ptr_d = do_wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(do_wr) - OCC_W'(pop);
        if (flush_now) begin
            do_wr    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            infl_d   = '0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            infl_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= infl_d;
            if (do_wr) begin
                buf_q[wr_ptr_q] <= rdata;
            end
        end
    end

    // An arrival that finds no room means the credit logic is broken.
    always_ff @(posedge rclk) begin
        if (rrst_n) begin
            assert (!(arrive && !flush_now && !do_wr));
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: RD_LATENCY 1 and 2 instances, random FIFO/back-pressure
// traffic, expected words queued at read issue and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BD = 3;
    localparam int NI = 2;
    localparam int OW = $clog2(BD + 1);

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_STALL  = 2;
    localparam int M_TOGGLE = 3;
    localparam int M_RAND   = 4;
    localparam int M_FLUSH  = 5;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          empty     [NI];
    logic [DW-1:0] rdata     [NI];
    logic          r_en      [NI];
    logic          m_valid   [NI];
    logic [DW-1:0] m_data    [NI];
    logic          m_ready   [NI];
    logic [OW-1:0] occupancy [NI];
`ifdef FIFO_RD_STREAM_FLUSH_EN
    logic          flush     [NI];
`endif

    always #5 rclk = ~rclk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fifo_rd_stream #(
            .DATA_WIDTH(DW),
            .RD_LATENCY(g + 1),
            .BUF_DEPTH (BD)
        ) u_dut (
            .rclk     (rclk),
            .rrst_n   (rrst_n),
            .empty    (empty[g]),
            .rdata    (rdata[g]),
            .r_en     (r_en[g]),
            .m_valid  (m_valid[g]),
            .m_data   (m_data[g]),
            .m_ready  (m_ready[g]),
`ifdef FIFO_RD_STREAM_FLUSH_EN
            .flush    (flush[g]),
`endif
            .occupancy(occupancy[g])
        );
    end

    // Reference model: words issued but not yet delivered, their capture edges,
    // and the count of words already captured into the buffer.
    logic [DW-1:0] exp_q [NI][$];
    int            arr_q [NI][$];
    int            occ_m [NI];
    logic          pop_m [NI];
    logic          ren_m [NI];
    logic [DW-1:0] pipe  [NI][2];
    int            delivered [NI];
    int            cyc;
    int            checks;
    int            failures;
    logic          final_req;
    logic          final_done;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat=%0d cyc=%0d actual=%0h expected=%0h",
                     name, idx + 1, cyc, act, exp);
        end
    endtask

    // Monitor: status and data compared mid-cycle; reset outputs checked right after assertion.
    always @(negedge rclk or negedge rrst_n) begin
        if (cyc == 0) begin
            // bench still initialising
        end else if (!rrst_n && rclk) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                check("rst_r_en", i, 32'(r_en[i]), 32'd0);
                check("rst_m_valid", i, 32'(m_valid[i]), 32'd0);
                check("rst_m_data", i, 32'(m_data[i]), 32'd0);
                check("rst_occupancy", i, 32'(occupancy[i]), 32'd0);
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                logic fl;
                int   outstanding;
                fl = 1'b0;
`ifdef FIFO_RD_STREAM_FLUSH_EN
                fl = flush[i];
`endif
                check("occupancy", i, 32'(occupancy[i]), 32'(occ_m[i]));
                check("m_valid", i, 32'(m_valid[i]), 32'(occ_m[i] != 0));
                pop_m[i] = rrst_n && (occ_m[i] != 0) && m_ready[i] && !fl;
                if (pop_m[i]) begin
                    check("m_data", i, 32'(m_data[i]), 32'(exp_q[i].pop_front()));
                    delivered[i]++;
                end
                outstanding = occ_m[i] + arr_q[i].size() - (pop_m[i] ? 1 : 0);
                ren_m[i] = rrst_n && !empty[i] && !fl && (outstanding < BD);
                check("r_en", i, 32'(r_en[i]), 32'(ren_m[i]));
                if (final_req && !final_done) begin
                    check("drain_left", i, 32'(exp_q[i].size()), 32'd0);
                    check("delivered_many", i, 32'(delivered[i] > 100), 32'd1);
                end
            end
            if (final_req) final_done = 1'b1;
        end
    end

    // One clock edge: advance the model and the FIFO memory read pipe.
    task automatic step();
        @(posedge rclk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            logic          fl;
            logic [DW-1:0] w;
            fl = 1'b0;
`ifdef FIFO_RD_STREAM_FLUSH_EN
            fl = flush[i];
`endif
            if (fl) begin
                occ_m[i] = 0;
                exp_q[i].delete();
                arr_q[i].delete();
            end else if (pop_m[i]) begin
                occ_m[i]--;
            end
            pipe[i][1] = pipe[i][0];
            w = DW'($urandom);
            pipe[i][0] = w;
            if (ren_m[i]) begin
                exp_q[i].push_back(w);
                arr_q[i].push_back(cyc + i + 1);
            end
            while (arr_q[i].size() > 0 && arr_q[i][0] == cyc) begin
                void'(arr_q[i].pop_front());
                occ_m[i]++;
            end
            rdata[i] = pipe[i][i];
        end
    endtask

    task automatic drive(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                M_IDLE:   begin empty[i] = 1'b1; m_ready[i] = 1'b1; end
                M_STREAM: begin empty[i] = 1'b0; m_ready[i] = 1'b1; end
                M_STALL:  begin empty[i] = 1'b0; m_ready[i] = 1'b0; end
                M_TOGGLE: begin empty[i] = 1'b0; m_ready[i] = (cyc % 2 == 0); end
                default: begin
                    empty[i]   = ($urandom_range(0, 3) == 0);
                    m_ready[i] = ($urandom_range(0, 2) != 0);
                end
            endcase
`ifdef FIFO_RD_STREAM_FLUSH_EN
            flush[i] = (mode == M_FLUSH) && ($urandom_range(0, 11) == 0);
`endif
        end
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            step();
            drive(mode);
        end
    endtask

    task automatic mid_reset();
        #1 rrst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            occ_m[i] = 0;
            exp_q[i].delete();
            arr_q[i].delete();
            empty[i] = 1'b1;
        end
        run(2, M_IDLE);
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n     = 1'b0;
        cyc        = 0;
        checks     = 0;
        failures   = 0;
        final_req  = 1'b0;
        final_done = 1'b0;
        for (int i = 0; i < NI; i++) begin
            empty[i]     = 1'b1;
            m_ready[i]   = 1'b0;
            rdata[i]     = '0;
            occ_m[i]     = 0;
            pop_m[i]     = 1'b0;
            ren_m[i]     = 1'b0;
            pipe[i][0]   = '0;
            pipe[i][1]   = '0;
            delivered[i] = 0;
`ifdef FIFO_RD_STREAM_FLUSH_EN
            flush[i]     = 1'b0;
`endif
        end
        run(3, M_IDLE);
        rrst_n = 1'b1;
        run(10, M_IDLE);
        run(30, M_STREAM);
        run(10, M_STALL);
        run(20, M_STREAM);
        run(40, M_TOGGLE);
        run(300, M_RAND);
        run(1, M_STREAM);
        run(8, M_IDLE);
        run(20, M_STREAM);
        mid_reset();
        run(3, M_IDLE);
        run(150, M_RAND);
`ifdef FIFO_RD_STREAM_FLUSH_EN
        run(200, M_FLUSH);
`endif
        run(20, M_IDLE);
        final_req = 1'b1;
        repeat (3) @(posedge rclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-domain consumer for the async FIFO. It drives the FIFO read enable from the read-pointer handler's empty flag. It absorbs the memory's fixed read latency and presents words as a valid/ready stream on rclk. A small internal skid buffer sustains one word per cycle under back-pressure without overrunning or dropping data.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and stream data
RD_LATENCY, 1, rclk cycles from r_en sampled high to rdata valid (legal: 1 or 2)
BUF_DEPTH, 3, skid buffer entries; must be >= RD_LATENCY+1 for full throughput (legal 2..8)

Ports:
rclk  in  1  read-domain clock
rrst_n  in  1  reset, asynchronous, active-low
empty  in  1  FIFO empty flag from read-pointer handler, registered in rclk
rdata  in  DATA_WIDTH  FIFO memory read data, valid RD_LATENCY cycles after an accepted r_en
r_en  out  1  FIFO read request, combinational from registered state and empty
m_valid  out  1  stream data valid
m_data  out  DATA_WIDTH  stream data, head of skid buffer
m_ready  in  1  downstream accept
occupancy  out  $clog2(BUF_DEPTH+1)  words held in skid buffer (excludes in-flight)

Behaviour:
- Reset (rrst_n low, async): r_en=0, m_valid=0, m_data=0, occupancy=0, in-flight pipe cleared, buffer pointers 0.
- Pop: pop = m_valid & m_ready. On a pop, the head entry is removed at the next rclk edge.
- In-flight tracking: shift register infl[RD_LATENCY-1:0]. infl[0] loads r_en each cycle. At the tail bit, the word on rdata is written into the buffer. inflight = popcount(infl).
- Credit rule: r_en = !empty & (occupancy + inflight - pop < BUF_DEPTH). Subtract with sufficient width; no underflow because pop implies occupancy >= 1.
- Buffer: circular array of BUF_DEPTH entries with wr_ptr/rd_ptr wrapping modulo BUF_DEPTH (non-power-of-2 depth allowed).
  - occupancy_next = occupancy + arrive - pop.
  - Simultaneous arrive and pop: occupancy unchanged, both pointers advance.
- Output: m_valid = (occupancy != 0). m_data = buf[rd_ptr] (registered storage; no rdata-to-m_data bypass).
- Minimum latency: r_en high at edge N → rdata captured at edge N+RD_LATENCY → m_valid high after that edge.
- Stream rules:
  - m_data is stable while m_valid & !m_ready.
  - m_valid is never deasserted without a pop.
- Full buffer: the credit rule guarantees an arrival never finds the buffer full. This is an assertion target. Overflow is a design error; in that case the write is ignored and occupancy saturates.
- empty toggling: r_en follows empty in the same cycle. An empty de-assertion lets a read issue the same cycle if credit is available.
- Steady state with m_ready=1 and a non-empty FIFO: r_en high every cycle, one word per cycle out.
- Reset mid-operation: in-flight words are discarded. The FIFO read pointer resets on the same rrst_n, so this is consistent.

Optional Feature:
FIFO_RD_STREAM_FLUSH_EN
- Defined: adds input port flush (1 bit, rclk).
  - While flush=1: r_en forced 0.
  - At the next edge: occupancy, pointers and infl are cleared, and m_valid=0.
  - Words arriving from reads issued before flush are dropped.
  - pop is ignored in the flush cycle.
- Not defined: no flush port, no flush logic.

Test Plan:
- Reset then empty=1 for 10 cycles → r_en=0, m_valid=0, occupancy=0 throughout.
- RD_LATENCY=1, empty=0, m_ready=1, rdata=0x01,0x02,… → r_en high every cycle; m_data 0x01,0x02,… one per cycle; first m_valid 2 edges after first r_en; occupancy ≤1.
- Fill then stall: m_ready=0 with a non-empty FIFO → exactly 3 reads issued, occupancy=3, r_en=0. Release m_ready → words out in order, no gaps, no loss.
- RD_LATENCY=2, BUF_DEPTH=3, m_ready toggled 1/0 every cycle → output order matches input order, never more than 3 outstanding (occupancy+inflight ≤ 3), no overflow assertion.
- empty rises while 1 read in flight → in-flight word still delivered; r_en=0 until empty=0; reset asserted mid-stream → all outputs 0 asynchronously.
- With FIFO_RD_STREAM_FLUSH_EN: 2 buffered + 1 in flight, pulse flush → m_valid=0 next cycle, occupancy=0, in-flight word dropped; next read after flush delivered normally.
